// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states,
// default memory read latency and the alignment legality check.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int MEM_LAT_DEFAULT = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RESP = 2'b11
  } lsu_state_e;

  // An access is legal when its size is defined and its byte address is
  // naturally aligned to that size.
  function automatic logic is_legal(input logic [1:0] size, input logic [1:0] addr_lo);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~addr_lo[0];
      SZ_WORD: ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends the addressed byte/half of a
// memory word for loads, and merges store data into the addressed lane(s) of
// a memory word for read-modify-write stores. Little-endian lanes.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] read_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Load path: pick the addressed lane and sign- or zero-extend it.
  always_comb begin
    lane_b    = read_word[{addr_lo, 3'b000} +: 8];
    lane_h    = addr_lo[1] ? read_word[31:16] : read_word[15:0];
    load_data = read_word;
    case (size)
      SZ_BYTE: load_data = is_unsigned ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      SZ_HALF: load_data = is_unsigned ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_data = read_word;
    endcase
  end

  // Store path: replace only the addressed lane(s); a word store takes the data whole.
  always_comb begin
    store_word = read_word;
    case (size)
      SZ_BYTE: store_word[{addr_lo, 3'b000} +: 8] = store_data[7:0];
      SZ_HALF: begin
        if (addr_lo[1]) store_word[31:16] = store_data[15:0];
        else            store_word[15:0]  = store_data[15:0];
      end
      default: store_word = store_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request from the MEM stage, runs it against a
// word-wide data memory (read, write or read-modify-write), and returns one
// response pulse. Every output is a flop; the FSM is exposed on state_o.
//
// Request handshake: a request transfers on a rising edge where req_valid_i
// and req_ready_o are both 1. req_ready_o is 1 only in IDLE; while the unit is
// busy the producer holds its request and req_valid_i is ignored. The
// response is a single-cycle resp_valid_o pulse with no backpressure; the next
// request can be accepted in the cycle after the response.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEFAULT,
  parameter int AW      = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_we_i,
  input  logic [1:0]    req_size_i,
  input  logic          req_unsigned_i,
  input  logic [AW-1:0] req_addr_i,
  input  logic [31:0]   req_wdata_i,
  output logic          resp_valid_o,
  output logic [31:0]   resp_rdata_o,
  output logic          resp_err_o,
  output logic [AW-1:0] address_o,
  output logic          Memory_read_o,
  output logic          Memory_write_o,
  output logic [31:0]   write_data_o,
  input  logic [31:0]   read_data_i,
  output logic [1:0]    state_o
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  lsu_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Request fields captured at accept; the upper address bits live in address_o.
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] wdata_q;
  logic        latch;

  // Output registers and their next values.
  logic          ready_q, ready_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic          resp_v_q, resp_v_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdo_q, wdo_d;

  logic [31:0] load_data;
  logic [31:0] store_word;
  logic        accept;

  assign accept = req_valid_i & ready_q;

  // Lane logic works on the captured request and the live memory read data,
  // which is only consumed on the final RD edge.
  lsu_align u_align (
    .size        (size_q),
    .addr_lo     (addr_lo_q),
    .is_unsigned (uns_q),
    .read_word   (read_data_i),
    .store_data  (wdata_q),
    .load_data   (load_data),
    .store_word  (store_word)
  );

  // Next state and next output values; outputs are decided one cycle ahead so
  // each lands in a flop.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch    = 1'b0;
    ready_d  = 1'b0;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    resp_v_d = 1'b0;
    err_d    = 1'b0;
    rdata_d  = 32'h0;
    addr_d   = addr_q;
    wdo_d    = wdo_q;
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          latch   = 1'b1;
          ready_d = 1'b0;
          if (!is_legal(req_size_i, req_addr_i[1:0])) begin
            state_d  = ST_RESP;
            resp_v_d = 1'b1;
            err_d    = 1'b1;
          end else begin
            addr_d = {req_addr_i[AW-1:2], 2'b00};
            if (req_we_i && (req_size_i == SZ_WORD)) begin
              state_d = ST_WR;
              wr_d    = 1'b1;
              wdo_d   = req_wdata_i;
            end else begin
              state_d = ST_RD;
              rd_d    = 1'b1;
              cnt_d   = CW'(MEM_LAT - 1);
            end
          end
        end
      end
      ST_RD: begin
        if (cnt_q == '0) begin
          if (we_q) begin
            state_d = ST_WR;
            wr_d    = 1'b1;
            wdo_d   = store_word;
          end else begin
            state_d  = ST_RESP;
            resp_v_d = 1'b1;
            rdata_d  = load_data;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
          rd_d  = 1'b1;
        end
      end
      ST_WR: begin
        state_d  = ST_RESP;
        resp_v_d = 1'b1;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State, counter and output registers; reset aborts any access in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      resp_v_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
      addr_q   <= '0;
      wdo_q    <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      resp_v_q <= resp_v_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
      wdo_q    <= wdo_d;
    end
  end

  // Capture the request fields on accept and hold them for the whole access.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      we_q      <= 1'b0;
      size_q    <= SZ_BYTE;
      uns_q     <= 1'b0;
      addr_lo_q <= 2'b00;
      wdata_q   <= 32'h0;
    end else if (latch) begin
      we_q      <= req_we_i;
      size_q    <= req_size_i;
      uns_q     <= req_unsigned_i;
      addr_lo_q <= req_addr_i[1:0];
      wdata_q   <= req_wdata_i;
    end
  end

  assign req_ready_o    = ready_q;
  assign resp_valid_o   = resp_v_q;
  assign resp_err_o     = err_q;
  assign resp_rdata_o   = rdata_q;
  assign address_o      = addr_q;
  assign Memory_read_o  = rd_q;
  assign Memory_write_o = wr_q;
  assign write_data_o   = wdo_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: a depth-8 word memory model with a
// configurable read latency, directed request vectors with hand-computed
// results, and a response scoreboard fed by the driver and drained by a monitor.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int MEM_LAT = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  logic        req_valid;
  logic        req_ready_o;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic [31:0] address_o;
  logic        Memory_read_o;
  logic        Memory_write_o;
  logic [31:0] write_data_o;
  logic [31:0] read_data_i;
  logic [1:0]  dbg_state;

  load_store_unit #(.MEM_LAT(MEM_LAT), .AW(32)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we),
    .req_size_i     (req_size),
    .req_unsigned_i (req_unsigned),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .resp_valid_o   (resp_valid_o),
    .resp_rdata_o   (resp_rdata_o),
    .resp_err_o     (resp_err_o),
    .address_o      (address_o),
    .Memory_read_o  (Memory_read_o),
    .Memory_write_o (Memory_write_o),
    .write_data_o   (write_data_o),
    .read_data_i    (read_data_i),
    .state_o        (dbg_state)
  );

  // ---------------- memory model ----------------
  logic [31:0] mem [8] = '{default: 32'h0};
  logic        pre_en = 1'b0;
  logic [2:0]  pre_idx = 3'd0;
  logic [31:0] pre_val = 32'h0;
  int          rd_cnt = 0;
  int          cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pre_en) mem[pre_idx] <= pre_val;
    else if (Memory_write_o) mem[address_o[4:2]] <= write_data_o;
    rd_cnt <= Memory_read_o ? rd_cnt + 1 : 0;
  end

  // Data is only valid once the read has been held for MEM_LAT cycles.
  always_comb begin
    read_data_i = 32'hBAD0_BAD0;
    if (Memory_read_o && (rd_cnt == MEM_LAT - 1)) read_data_i = mem[address_o[4:2]];
  end

  // ---------------- scoreboard ----------------
  logic [40:0] exp_q[$];   // {err, rdata, latency}
  int          acc_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          rd_cycles = 0;
  int          wr_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the oldest expected response whenever the DUT responds.
  always @(negedge clk) begin
    logic [40:0] e;
    int          a;
    if (rst_i) begin
      if (Memory_read_o)  rd_cycles++;
      if (Memory_write_o) wr_cycles++;
      if (Memory_read_o || Memory_write_o)
        check("strobe_overlap", {31'h0, Memory_read_o & Memory_write_o}, 32'h0);
      if (resp_valid_o) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          check("unexpected_resp", 32'h1, 32'h0);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("resp_rdata", resp_rdata_o, e[39:8]);
          check("resp_err", {31'h0, resp_err_o}, {31'h0, e[40]});
          check("resp_latency", 32'(cyc - a), {24'h0, e[7:0]});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clk);
    pre_en  = 1'b1;
    pre_idx = 3'(idx);
    pre_val = val;
    @(negedge clk);
    pre_en  = 1'b0;
  endtask

  // Presents a request, waits for it to be accepted and records the expected
  // response. req_valid stays high afterwards so requests can be chained.
  task automatic send(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    int waited = 0;
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    while (!req_ready_o && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready_o) begin
      check("accept_timeout", 32'h0, 32'h1);
    end else begin
      exp_q.push_back({exp_err, exp_rdata, 8'(exp_lat)});
      acc_q.push_back(cyc);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    req_valid = 1'b0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'h0);
      exp_q.delete();
      acc_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},  {31'h0, req_ready_o},    32'h1);
    check({tag, "_rvalid"}, {31'h0, resp_valid_o},   32'h0);
    check({tag, "_err"},    {31'h0, resp_err_o},     32'h0);
    check({tag, "_rd"},     {31'h0, Memory_read_o},  32'h0);
    check({tag, "_wr"},     {31'h0, Memory_write_o}, 32'h0);
    check({tag, "_addr"},   address_o,               32'h0);
    check({tag, "_wdata"},  write_data_o,            32'h0);
    check({tag, "_rdata"},  resp_rdata_o,            32'h0);
    check({tag, "_state"},  {30'h0, dbg_state},      {30'h0, ST_IDLE});
  endtask

  // ---------------- directed sequence ----------------
  int rd0, wr0;

  initial begin
    rst_i        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = SZ_WORD;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_i = 1'b1;
    @(negedge clk);

    // 1: word store goes straight to a single write
    rd0 = rd_cycles; wr0 = wr_cycles;
    send(1'b1, SZ_WORD, 1'b0, 32'h08, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
    drain();
    check("sw_mem2", mem[2], 32'hDEAD_BEEF);
    check("sw_wr_cycles", 32'(wr_cycles - wr0), 32'd1);
    check("sw_rd_cycles", 32'(rd_cycles - rd0), 32'd0);

    // 2: loads with sign/zero extension across lanes
    preload(1, 32'h80FF_7F01);
    send(1'b0, SZ_BYTE, 1'b0, 32'h07, 32'h0, 32'hFFFF_FF80, 1'b0, MEM_LAT + 1);
    send(1'b0, SZ_BYTE, 1'b1, 32'h07, 32'h0, 32'h0000_0080, 1'b0, MEM_LAT + 1);
    send(1'b0, SZ_HALF, 1'b0, 32'h04, 32'h0, 32'h0000_7F01, 1'b0, MEM_LAT + 1);
    send(1'b0, SZ_HALF, 1'b0, 32'h06, 32'h0, 32'hFFFF_80FF, 1'b0, MEM_LAT + 1);
    send(1'b0, SZ_HALF, 1'b1, 32'h06, 32'h0, 32'h0000_80FF, 1'b0, MEM_LAT + 1);
    send(1'b0, SZ_BYTE, 1'b0, 32'h05, 32'h0, 32'h0000_007F, 1'b0, MEM_LAT + 1);
    send(1'b0, SZ_WORD, 1'b0, 32'h04, 32'h0, 32'h80FF_7F01, 1'b0, MEM_LAT + 1);
    drain();

    // 3: sub-word stores use read-modify-write
    preload(2, 32'h1122_3344);
    rd0 = rd_cycles; wr0 = wr_cycles;
    send(1'b1, SZ_BYTE, 1'b0, 32'h09, 32'h1234_56AA, 32'h0, 1'b0, MEM_LAT + 2);
    drain();
    check("sb_mem2", mem[2], 32'h1122_AA44);
    check("sb_rd_cycles", 32'(rd_cycles - rd0), 32'(MEM_LAT));
    check("sb_wr_cycles", 32'(wr_cycles - wr0), 32'd1);
    send(1'b1, SZ_HALF, 1'b0, 32'h0A, 32'hFFFF_BEEF, 32'h0, 1'b0, MEM_LAT + 2);
    drain();
    check("sh_mem2", mem[2], 32'hBEEF_AA44);

    // 4: misaligned and illegal-size requests fail fast without touching memory
    rd0 = rd_cycles; wr0 = wr_cycles;
    send(1'b0, SZ_WORD, 1'b0, 32'h06, 32'h0, 32'h0, 1'b1, 1);
    send(1'b0, SZ_HALF, 1'b0, 32'h03, 32'h0, 32'h0, 1'b1, 1);
    send(1'b0, 2'b11,   1'b0, 32'h00, 32'h0, 32'h0, 1'b1, 1);
    send(1'b1, SZ_WORD, 1'b0, 32'h02, 32'h5555_5555, 32'h0, 1'b1, 1);
    drain();
    check("err_rd_cycles", 32'(rd_cycles - rd0), 32'd0);
    check("err_wr_cycles", 32'(wr_cycles - wr0), 32'd0);
    check("err_mem0", mem[0], 32'h0);

    // 5: reset during the read phase of a byte store aborts it
    preload(3, 32'h5566_7788);
    wr0 = wr_cycles;
    send(1'b1, SZ_BYTE, 1'b0, 32'h0C, 32'h0000_0011, 32'h0, 1'b0, MEM_LAT + 2);
    @(negedge clk);
    check("abort_in_rd", {31'h0, Memory_read_o}, 32'h1);
    req_valid = 1'b0;
    rst_i = 1'b0;
    #1;
    exp_q.delete();
    acc_q.delete();
    check_reset_outputs("abort");
    repeat (3) @(negedge clk);
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_mem3", mem[3], 32'h5566_7788);
    check("abort_wr_cycles", 32'(wr_cycles - wr0), 32'd0);
    send(1'b0, SZ_WORD, 1'b0, 32'h0C, 32'h0, 32'h5566_7788, 1'b0, MEM_LAT + 1);
    drain();

    // 6: valid held high across back-to-back mixed requests
    send(1'b1, SZ_WORD, 1'b0, 32'h10, 32'h0000_CAFE, 32'h0, 1'b0, 2);
    send(1'b0, SZ_HALF, 1'b0, 32'h10, 32'h0, 32'hFFFF_CAFE, 1'b0, MEM_LAT + 1);
    send(1'b1, SZ_BYTE, 1'b0, 32'h13, 32'h0000_0001, 32'h0, 1'b0, MEM_LAT + 2);
    send(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h0100_CAFE, 1'b0, MEM_LAT + 1);
    drain();
    check("b2b_mem4", mem[4], 32'h0100_CAFE);

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Guard against a hung handshake.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
